fcmp_seq: RTL and testbench

Shared floating-point compare/min-max unit for single-precision operands, arbitrating between two requesters: the FP pipe and the integer-writeback path. A round-robin arbiter selects one request at a time. The block latches the operands, evaluates FLE/FLT/FEQ/FMIN/FMAX per IEEE-754/RISC-V F semantics, and holds the result plus the invalid flag on a valid/ready response port until it is consumed.

---
 rtl/fcmp_pkg.sv | 40 ++++
 rtl/fcmp_seq_if.sv | 26 ++
 rtl/fcmp_core.sv | 66 ++++++
 rtl/fcmp_seq.sv | 98 +++++++++
 tb/tb_fcmp_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fcmp_pkg.sv
// Shared definitions for the FP compare/min-max unit: op encodings, the canonical
// NaN, controller states and the total-order key used by the comparator.
package fcmp_pkg;

  localparam logic [2:0] OP_FLE  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FEQ  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b100;
  localparam logic [2:0] OP_FMAX = 3'b101;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } fcmp_state_e;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_CMP  = S_CMP;
  localparam logic [1:0] ST_RESP = S_RESP;

  // Maps a non-NaN float onto an unsigned key whose order matches the numeric
  // order, with -0 placed just below +0.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[31])
      order_key = ~x;
    else
      order_key = x | 32'h8000_0000;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    is_snan = is_nan(x) && !x[22];
  endfunction

endpackage

// File: rtl/fcmp_seq_if.sv
// Request/response bundle between the two requesters, the consumer and fcmp_seq.
interface fcmp_seq_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_nv;

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_nv
  );

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_nv
  );
endinterface

// File: rtl/fcmp_core.sv
// Combinational single-precision compare / min / max with the invalid flag,
// following RISC-V F semantics for NaNs and signed zeros.
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        nv
);

  logic        nan_a, nan_b, any_nan, any_snan;
  logic        both_zero, eq, lt;
  logic [31:0] ka, kb;
  logic        key_lt;

  assign nan_a     = is_nan(a);
  assign nan_b     = is_nan(b);
  assign any_nan   = nan_a || nan_b;
  assign any_snan  = is_snan(a) || is_snan(b);
  assign ka        = order_key(a);
  assign kb        = order_key(b);
  assign key_lt    = ka < kb;
  // Keys separate -0 from +0, which is right for min/max but not for the compares.
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
  assign eq        = (a == b) || both_zero;
  assign lt        = key_lt && !both_zero;

  always_comb begin
    result = 32'd0;
    nv     = 1'b0;
    case (op)
      OP_FLE: begin
        nv        = any_nan;
        result[0] = !any_nan && (lt || eq);
      end
      OP_FLT: begin
        nv        = any_nan;
        result[0] = !any_nan && lt;
      end
      OP_FEQ: begin
        nv        = any_snan;
        result[0] = !any_nan && eq;
      end
      OP_FMIN, OP_FMAX: begin
        nv = any_snan;
        if (nan_a && nan_b)
          result = CANON_NAN;
        else if (nan_a)
          result = b;
        else if (nan_b)
          result = a;
        else if (op == OP_FMIN)
          result = key_lt ? a : b;
        else
          result = key_lt ? b : a;
      end
      default: begin
        result = 32'd0;
        nv     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fcmp_seq.sv
// Two-requester front end for fcmp_core: round-robin grant, operand latch,
// one evaluation cycle, then a held valid/ready response.
module fcmp_seq
  import fcmp_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  fcmp_seq_if.slave  bus
);

  logic [1:0]  state;
  logic        last_grant;
  logic        grant;
  logic [1:0]  ready;
  logic        accept;

  logic [2:0]  op_p0;
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic        id_p0;

  logic [31:0] core_result;
  logic        core_nv;

  logic [31:0] data_p1;
  logic        nv_p1;
  logic        id_p1;

  // Contending requests go to whoever was not served last.
  always_comb begin
    grant = last_grant;
    if (bus.req_valid == 2'b11)
      grant = ~last_grant;
    else if (bus.req_valid[0])
      grant = 1'b0;
    else if (bus.req_valid[1])
      grant = 1'b1;
  end

  assign ready         = (state == ST_IDLE) ? ({grant, ~grant} & bus.req_valid) : 2'b00;
  assign accept        = |ready;
  assign bus.req_ready = ready;

  // Stage p0: operands of the accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= grant ? bus.req1_op : bus.req0_op;
      a_p0  <= grant ? bus.req1_a  : bus.req0_a;
      b_p0  <= grant ? bus.req1_b  : bus.req0_b;
      id_p0 <= grant;
    end
  end

  fcmp_core u_core (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .result (core_result),
    .nv     (core_nv)
  );

  // Stage p1: registered response, written only on the CMP to RESP transition.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      data_p1    <= 32'd0;
      nv_p1      <= 1'b0;
      id_p1      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= grant;
            state      <= ST_CMP;
          end
        end
        ST_CMP: begin
          data_p1 <= core_result;
          nv_p1   <= core_nv;
          id_p1   <= id_p0;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = data_p1;
  assign bus.rsp_nv    = nv_p1;
  assign bus.rsp_id    = id_p1;

endmodule

// File: tb/tb_fcmp_seq.sv
// Scoreboard bench for fcmp_seq: a cycle-level timeline model predicts grants and
// response timing, and an arithmetic float model predicts each result.
module tb_fcmp_seq;
  import fcmp_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fcmp_seq_if bif ();

  fcmp_seq u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        nv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;

  logic m_idle = 1'b1;
  logic m_last = 1'b1;
  logic m_pend = 1'b0;
  int   m_age = 0;
  logic just_rst = 1'b0;
  logic m_acc, m_g, m_vld;
  logic [1:0] m_rdy;
  logic [32:0] m_res;
  exp_t e;

  function automatic bit f_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit f_snan(logic [31:0] x);
    return f_nan(x) && (x[22] == 1'b0);
  endfunction

  function automatic bit f_zero(logic [31:0] x);
    return x[30:0] == 0;
  endfunction

  // Numeric a<b for non-NaN operands using sign and magnitude; zeros are equal.
  function automatic bit f_less(logic [31:0] a, logic [31:0] b);
    if (f_zero(a) && f_zero(b)) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  // Returns {nv, result}.
  function automatic logic [32:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    bit na, nb, anyn, anys, lt, eq;
    logic [31:0] r;
    na   = f_nan(a);
    nb   = f_nan(b);
    anyn = na || nb;
    anys = f_snan(a) || f_snan(b);
    lt   = f_less(a, b);
    eq   = (a == b) || (f_zero(a) && f_zero(b));
    case (op)
      3'b000: return {anyn, 31'd0, (!anyn && (lt || eq))};
      3'b001: return {anyn, 31'd0, (!anyn && lt)};
      3'b010: return {anys, 31'd0, (!anyn && eq)};
      3'b100, 3'b101: begin
        if (na && nb) r = 32'h7FC0_0000;
        else if (na) r = b;
        else if (nb) r = a;
        else if (f_zero(a) && f_zero(b))
          r = (op == 3'b100) ? (a[31] ? a : b) : (a[31] ? b : a);
        else if (op == 3'b100) r = lt ? a : b;
        else r = lt ? b : a;
        return {anys, r};
      end
      default: return 33'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: timeline model of grant/latency plus scoreboard compare.
  always @(negedge clk) begin
    if (resetn) begin
      q.delete();
      m_idle   = 1'b1;
      m_last   = 1'b1;
      m_pend   = 1'b0;
      m_age    = 0;
      just_rst = 1'b1;
    end else begin
      if (just_rst) begin
        chk("reset_rsp_data", bif.rsp_data, 32'd0);
        chk("reset_rsp_nv", {31'd0, bif.rsp_nv}, 32'd0);
        chk("reset_rsp_id", {31'd0, bif.rsp_id}, 32'd0);
        just_rst = 1'b0;
      end
      if (m_pend) m_age++;
      m_acc = m_idle && (bif.req_valid != 2'b00);
      m_g   = (bif.req_valid == 2'b11) ? ~m_last : (bif.req_valid == 2'b10);
      m_rdy = m_acc ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", {30'd0, bif.req_ready}, {30'd0, m_rdy});
      m_vld = m_pend && (m_age >= 2);
      chk("rsp_valid", {31'd0, bif.rsp_valid}, {31'd0, m_vld});
      if (m_vld && q.size() > 0) begin
        chk("rsp_data", bif.rsp_data, q[0].data);
        chk("rsp_nv", {31'd0, bif.rsp_nv}, {31'd0, q[0].nv});
        chk("rsp_id", {31'd0, bif.rsp_id}, {31'd0, q[0].id});
        if (bif.rsp_ready) begin
          void'(q.pop_front());
          m_pend = 1'b0;
          m_idle = 1'b1;
          rsp_count++;
        end
      end
      if (m_acc) begin
        m_res  = m_g ? ref_model(bif.req1_op, bif.req1_a, bif.req1_b)
                     : ref_model(bif.req0_op, bif.req0_a, bif.req0_b);
        e.id   = m_g;
        e.data = m_res[31:0];
        e.nv   = m_res[32];
        q.push_back(e);
        m_last = m_g;
        m_idle = 1'b0;
        m_pend = 1'b1;
        m_age  = 0;
      end
    end
  end

  task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bif.req1_op = op; bif.req1_a = a; bif.req1_b = b;
    end else begin
      bif.req0_op = op; bif.req0_a = a; bif.req0_b = b;
    end
  endtask

  task automatic wait_grant(input logic [1:0] mask);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((bif.req_ready & mask) == 2'b00) && n < 30);
    if ((bif.req_ready & mask) == 2'b00) begin
      errors++;
      $display("FAIL grant_timeout: req_ready %b mask %b", bif.req_ready, mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bif.rsp_valid && bif.rsp_ready) && n < 30);
    if (!(bif.rsp_valid && bif.rsp_ready)) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid %b rsp_ready %b", bif.rsp_valid, bif.rsp_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    set_req(id, op, a, b);
    bif.req_valid[id] = 1'b1;
    wait_grant(id ? 2'b10 : 2'b01);
    bif.req_valid[id] = 1'b0;
    wait_rsp();
  endtask

  task automatic pulse_reset();
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000;
      3: return {r[31], 9'h1FE, 1'b0, r[21:1], 1'b1};
      4: return {r[31], 31'h7F80_0000};
      5: return 32'h3F80_0000;
      6: return 32'hBF80_0000;
      default: return r;
    endcase
  endfunction

  initial begin
    resetn = 1'b1;
    bif.req_valid = 2'b00;
    bif.rsp_ready = 1'b1;
    set_req(1'b0, 3'b000, 32'd0, 32'd0);
    set_req(1'b1, 3'b000, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, OP_FLE,  32'h3F80_0000, 32'h4000_0000);
    issue(1'b1, OP_FEQ,  32'h8000_0000, 32'h0000_0000);
    issue(1'b1, OP_FLT,  32'h7F80_0001, 32'h3F80_0000);
    issue(1'b0, OP_FEQ,  32'h7FC0_0000, 32'h3F80_0000);
    issue(1'b0, OP_FLE,  32'h7FC0_0000, 32'h3F80_0000);
    issue(1'b1, OP_FMIN, 32'h0000_0000, 32'h8000_0000);
    issue(1'b0, OP_FMAX, 32'h8000_0000, 32'h0000_0000);
    issue(1'b0, OP_FMAX, 32'h7FC0_0000, 32'h4040_0000);
    issue(1'b1, OP_FMAX, 32'h7FC0_0000, 32'h7FC0_0000);
    issue(1'b0, OP_FMIN, 32'h7F80_0001, 32'hC000_0000);
    issue(1'b1, 3'b011,  32'h3F80_0000, 32'h3F80_0000);
    issue(1'b0, OP_FLT,  32'hC000_0000, 32'hBF80_0000);

    // Contention straight after reset: grants must alternate starting at 0.
    pulse_reset();
    set_req(1'b0, OP_FLT, 32'h3F80_0000, 32'h4000_0000);
    set_req(1'b1, OP_FMAX, 32'hC040_0000, 32'h4040_0000);
    bif.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) wait_rsp();
    bif.req_valid = 2'b00;

    // Consumer stall with a competing request pending.
    bif.rsp_ready = 1'b0;
    set_req(1'b0, OP_FMIN, 32'h4040_0000, 32'hC040_0000);
    bif.req_valid = 2'b01;
    wait_grant(2'b01);
    bif.req_valid = 2'b10;
    repeat (7) @(posedge clk);
    #1;
    bif.req_valid = 2'b00;
    bif.rsp_ready = 1'b1;
    wait_rsp();

    // Reset while the request is being evaluated: its response is dropped.
    set_req(1'b1, OP_FEQ, 32'h3F80_0000, 32'h3F80_0000);
    bif.req_valid = 2'b10;
    wait_grant(2'b10);
    bif.req_valid = 2'b00;
    pulse_reset();
    repeat (3) @(posedge clk);
    #1;
    bif.req_valid = 2'b11;
    wait_grant(2'b01);
    bif.req_valid = 2'b00;
    wait_rsp();

    for (int i = 0; i < 600; i++) begin
      bif.req_valid = 2'($urandom_range(0, 3));
      set_req(1'b0, 3'($urandom_range(0, 7)), pick(), pick());
      set_req(1'b1, 3'($urandom_range(0, 7)), pick(), pick());
      bif.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bif.req_valid = 2'b00;
    bif.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
